avalon_packet_enforcer: RTL and testbench

Parametrised, registered Avalon-ST protocol enforcer placed between an untrusted packet source and downstream consumers. It guarantees that the output stream is framing-legal, with every packet starting with sop and ending with eop. It repairs or discards illegal beats, truncates over-length packets, and reports each violation through error pulses and saturating counters. It adds one register stage with full backpressure support.

---
 rtl/avalon_packet_enforcer_pkg.sv | 35 +++
 rtl/avalon_st_if.sv | 18 +
 rtl/avalon_packet_enforcer_sat_err_counter.sv | 23 ++
 rtl/avalon_packet_enforcer.sv | 148 ++++++++++++++
 tb/tb_avalon_packet_enforcer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_packet_enforcer_pkg.sv
// Shared types and constants for the Avalon-ST packet enforcer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package avalon_packet_enforcer_pack;

   // Beat geometry the enforcer is built for; the top-level DATA_WIDTH_IN_BYTES must equal this.
   localparam int BEAT_BYTES   = 16;
   localparam int BEAT_DATA_W  = 8 * BEAT_BYTES;
   localparam int BEAT_EMPTY_W = (BEAT_BYTES > 1) ? $clog2(BEAT_BYTES) : 1;

   // Empty value of the synthetic closing beat: only one (zero) byte is meaningful.
   localparam logic [BEAT_EMPTY_W-1:0] SYNTH_EMPTY = BEAT_EMPTY_W'(BEAT_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      IN_PACKET,
      DROP
   } avalon_packet_enforcer_sm_t;

   typedef struct packed {
      logic [BEAT_DATA_W-1:0]  data;
      logic [BEAT_EMPTY_W-1:0] empty;
      logic                    sop;
      logic                    eop;
   } beat_t;

   // A forwarded beat keeps its data; empty only has meaning on the eop beat.
   function automatic beat_t pass_beat(input beat_t b);
      beat_t r;
      r = b;
      if (!b.eop) r.empty = '0;
      return r;
   endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle: data, empty, valid, ready, sop, eop.
// Latency: none (wires only).
// Backpressure: ready flows from slave back to master.
interface avalon_st_if #(
   parameter int DATA_WIDTH_IN_BYTES = 16
);
   localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

   logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
   logic [EMPTY_W-1:0]               empty;
   logic                             valid;
   logic                             ready;
   logic                             sop;
   logic                             eop;

   modport master (output data, output empty, output valid, output sop, output eop, input ready);
   modport slave  (input data, input empty, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/avalon_packet_enforcer_sat_err_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count reflects inc/clear one cycle after they are sampled.
// Backpressure: none; clear wins over a simultaneous inc.
module sat_err_counter #(
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     inc,
   input  logic                     clear,
   output logic [ERR_CNT_WIDTH-1:0] count
);

   // Count events, hold at all-ones, clear has priority.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/avalon_packet_enforcer.sv
// Registered Avalon-ST framing enforcer: repairs/drops illegal beats, truncates long packets, counts errors.
// Latency: 1 cycle from acceptance to enforced_msg.valid; no bubbles with a ready sink.
// Backpressure: untrusted_msg.ready follows output-register freedom; low while injecting a closing beat.
module avalon_packet_enforcer
   import avalon_packet_enforcer_pack::*;
#(
   parameter int DATA_WIDTH_IN_BYTES = BEAT_BYTES,
   parameter int MAX_PKT_LEN_BEATS   = 256,
   parameter int ERR_CNT_WIDTH       = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   avalon_st_if.slave               untrusted_msg,
   avalon_st_if.master              enforced_msg,
   input  logic                     counters_clear,
   output logic                     missing_sop_error,
   output logic                     double_sop_error,
   output logic                     length_error,
   output logic [ERR_CNT_WIDTH-1:0] missing_sop_cnt,
   output logic [ERR_CNT_WIDTH-1:0] double_sop_cnt,
   output logic [ERR_CNT_WIDTH-1:0] length_err_cnt
);

   localparam int DW    = 8 * DATA_WIDTH_IN_BYTES;
   localparam int CNT_W = $clog2(MAX_PKT_LEN_BEATS + 1);
   // Counter value at which the next non-eop beat is the last one allowed.
   localparam logic [CNT_W-1:0] LAST_MID = CNT_W'(MAX_PKT_LEN_BEATS - 1);

   avalon_packet_enforcer_sm_t state;
   logic [CNT_W-1:0]           beat_cnt;
   beat_t                      out_q;
   logic                       out_vld;
   beat_t                      in_beat;
   logic                       free;
   logic                       inject;
   logic                       accept;

   // Gather the incoming fields into one beat for the datapath.
   always_comb begin
      in_beat       = '0;
      in_beat.data  = untrusted_msg.data;
      in_beat.empty = untrusted_msg.empty;
      in_beat.sop   = untrusted_msg.sop;
      in_beat.eop   = untrusted_msg.eop;
   end

   // A sop inside an open packet is held off while a closing beat is emitted in its place.
   assign free                = ~out_vld | enforced_msg.ready;
   assign inject              = (state == IN_PACKET) & untrusted_msg.valid & untrusted_msg.sop;
   assign untrusted_msg.ready = free & ~rst & ~inject;
   assign accept              = untrusted_msg.valid & untrusted_msg.ready;

   assign enforced_msg.valid = out_vld;
   assign enforced_msg.data  = out_q.data[DW-1:0];
   assign enforced_msg.empty = out_q.empty;
   assign enforced_msg.sop   = out_q.sop;
   assign enforced_msg.eop   = out_q.eop;

   // Framing state machine, output register and registered error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         beat_cnt          <= '0;
         out_vld           <= 1'b0;
         out_q             <= '0;
         missing_sop_error <= 1'b0;
         double_sop_error  <= 1'b0;
         length_error      <= 1'b0;
      end else begin
         missing_sop_error <= 1'b0;
         double_sop_error  <= 1'b0;
         length_error      <= 1'b0;
         // Register drains when consumed unless something new is loaded below.
         if (free) out_vld <= 1'b0;

         if (inject && free) begin
            out_vld          <= 1'b1;
            out_q            <= '{data: '0, empty: SYNTH_EMPTY, sop: 1'b0, eop: 1'b1};
            double_sop_error <= 1'b1;
            state            <= IDLE;
            beat_cnt         <= '0;
         end else if (accept) begin
            case (state)
               IN_PACKET: begin
                  // A sop never gets here: inject keeps ready low for it.
                  out_vld <= 1'b1;
                  if (in_beat.eop) begin
                     out_q    <= pass_beat(in_beat);
                     state    <= IDLE;
                     beat_cnt <= '0;
                  end else if (beat_cnt == LAST_MID) begin
                     out_q        <= '{data: in_beat.data, empty: '0, sop: 1'b0, eop: 1'b1};
                     length_error <= 1'b1;
                     state        <= DROP;
                     beat_cnt     <= beat_cnt + 1'b1;
                  end else begin
                     out_q    <= pass_beat(in_beat);
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
               default: begin
                  // IDLE and DROP both restart cleanly on a sop.
                  if (in_beat.sop) begin
                     out_vld <= 1'b1;
                     out_q   <= pass_beat(in_beat);
                     if (in_beat.eop) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                     end else begin
                        state    <= IN_PACKET;
                        beat_cnt <= CNT_W'(1);
                     end
                  end else if (state == IDLE) begin
                     missing_sop_error <= 1'b1;
                  end else if (in_beat.eop) begin
                     state <= IDLE;
                  end
               end
            endcase
         end
      end
   end

   sat_err_counter #(.ERR_CNT_WIDTH(ERR_CNT_WIDTH)) u_missing_sop_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (missing_sop_error),
      .clear (counters_clear),
      .count (missing_sop_cnt)
   );

   sat_err_counter #(.ERR_CNT_WIDTH(ERR_CNT_WIDTH)) u_double_sop_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (double_sop_error),
      .clear (counters_clear),
      .count (double_sop_cnt)
   );

   sat_err_counter #(.ERR_CNT_WIDTH(ERR_CNT_WIDTH)) u_length_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (length_error),
      .clear (counters_clear),
      .count (length_err_cnt)
   );

endmodule

// File: tb/tb_avalon_packet_enforcer.sv
// Directed bench for avalon_packet_enforcer with short packets and narrow counters.
// Latency: observes output handshakes on the falling edge.
// Backpressure: sink ready driven from the stimulus sequence.
module tb_avalon_packet_enforcer;

   localparam int NB   = 16;
   localparam int MAXB = 4;
   localparam int CW   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          counters_clear = 1'b0;
   logic          missing_sop_error, double_sop_error, length_error;
   logic [CW-1:0] missing_sop_cnt, double_sop_cnt, length_err_cnt;

   always #5 clk = ~clk;

   avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) in_if ();
   avalon_st_if #(.DATA_WIDTH_IN_BYTES(NB)) out_if ();

   avalon_packet_enforcer #(
      .DATA_WIDTH_IN_BYTES (NB),
      .MAX_PKT_LEN_BEATS   (MAXB),
      .ERR_CNT_WIDTH       (CW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .untrusted_msg     (in_if),
      .enforced_msg      (out_if),
      .counters_clear    (counters_clear),
      .missing_sop_error (missing_sop_error),
      .double_sop_error  (double_sop_error),
      .length_error      (length_error),
      .missing_sop_cnt   (missing_sop_cnt),
      .double_sop_cnt    (double_sop_cnt),
      .length_err_cnt    (length_err_cnt)
   );

   typedef struct {
      logic [127:0] data;
      logic [3:0]   empty;
      logic         sop;
      logic         eop;
      int           cyc;
   } obs_t;

   obs_t got_q[$];
   obs_t exp_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_ms = 0, n_ds = 0, n_le = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output handshake and tally error-pulse cycles.
   always @(negedge clk) begin
      if (out_if.valid && out_if.ready) begin
         got_q.push_back('{data: out_if.data, empty: out_if.empty, sop: out_if.sop,
                           eop: out_if.eop, cyc: cyc});
      end
      if (missing_sop_error) n_ms++;
      if (double_sop_error)  n_ds++;
      if (length_error)      n_le++;
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present one beat and return just after the edge that accepts it (valid left high).
   task automatic drive(input logic [127:0] d, input logic [3:0] e, input logic s, input logic eo);
      bit done;
      done        = 1'b0;
      in_if.valid = 1'b1;
      in_if.data  = d;
      in_if.empty = e;
      in_if.sop   = s;
      in_if.eop   = eo;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_if.ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      if (!done) check_val("accept_timeout", 128'd0, 128'd1);
   endtask

   task automatic idle(input int n);
      in_if.valid = 1'b0;
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input logic [127:0] d, input logic [3:0] e, input logic s, input logic eo);
      exp_q.push_back('{data: d, empty: e, sop: s, eop: eo, cyc: 0});
   endtask

   task automatic compare_out(input string tag, input bit consecutive);
      int n;
      check_val({tag, "_nbeats"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_val($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
         check_val($sformatf("%s_empty%0d", tag, i), got_q[i].empty, exp_q[i].empty);
         check_val($sformatf("%s_sop%0d", tag, i), got_q[i].sop, exp_q[i].sop);
         check_val($sformatf("%s_eop%0d", tag, i), got_q[i].eop, exp_q[i].eop);
         if (consecutive && i > 0)
            check_val($sformatf("%s_gap%0d", tag, i), got_q[i].cyc - got_q[i-1].cyc, 1);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic clear_tallies();
      n_ms = 0;
      n_ds = 0;
      n_le = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_if.valid    = 1'b0;
      in_if.data     = '0;
      in_if.empty    = '0;
      in_if.sop      = 1'b0;
      in_if.eop      = 1'b0;
      out_if.ready   = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_out_valid", out_if.valid, 0);
      check_val("rst_out_sop", out_if.sop, 0);
      check_val("rst_out_eop", out_if.eop, 0);
      check_val("rst_out_data", out_if.data, 0);
      check_val("rst_out_empty", out_if.empty, 0);
      check_val("rst_in_ready", in_if.ready, 0);
      check_val("rst_pulses", {missing_sop_error, double_sop_error, length_error}, 0);
      check_val("rst_cnts", {missing_sop_cnt, double_sop_cnt, length_err_cnt}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      got_q.delete();
      clear_tallies();

      // Legal 4-beat packet, no bubbles, one-cycle latency
      drive(128'd1, 4'd0, 1'b1, 1'b0);
      check_val("t1_lat_valid", out_if.valid, 1);
      check_val("t1_lat_data", out_if.data, 1);
      drive(128'd2, 4'd0, 1'b0, 1'b0);
      drive(128'd3, 4'd0, 1'b0, 1'b0);
      drive(128'd4, 4'd3, 1'b0, 1'b1);
      idle(4);
      expect_beat(128'd1, 4'd0, 1'b1, 1'b0);
      expect_beat(128'd2, 4'd0, 1'b0, 1'b0);
      expect_beat(128'd3, 4'd0, 1'b0, 1'b0);
      expect_beat(128'd4, 4'd3, 1'b0, 1'b1);
      compare_out("t1", 1'b1);
      check_val("t1_pulses", n_ms + n_ds + n_le, 0);
      check_val("t1_cnts", {missing_sop_cnt, double_sop_cnt, length_err_cnt}, 0);

      // Missing sop in IDLE
      clear_tallies();
      drive(128'hAA, 4'd0, 1'b0, 1'b0);
      drive(128'hBB, 4'd0, 1'b1, 1'b1);
      idle(4);
      expect_beat(128'hBB, 4'd0, 1'b1, 1'b1);
      compare_out("t2", 1'b0);
      check_val("t2_ms_pulses", n_ms, 1);
      check_val("t2_ms_cnt", missing_sop_cnt, 1);

      // Double sop: synthetic closing beat inserted
      clear_tallies();
      drive(128'h10, 4'd0, 1'b1, 1'b0);
      drive(128'h11, 4'd0, 1'b0, 1'b0);
      drive(128'h12, 4'd0, 1'b1, 1'b0);
      drive(128'h13, 4'd7, 1'b0, 1'b1);
      idle(4);
      expect_beat(128'h10, 4'd0, 1'b1, 1'b0);
      expect_beat(128'h11, 4'd0, 1'b0, 1'b0);
      expect_beat(128'h0, 4'd15, 1'b0, 1'b1);
      expect_beat(128'h12, 4'd0, 1'b1, 1'b0);
      expect_beat(128'h13, 4'd7, 1'b0, 1'b1);
      compare_out("t3", 1'b1);
      check_val("t3_ds_pulses", n_ds, 1);
      check_val("t3_ds_cnt", double_sop_cnt, 1);

      // Over-length packet truncated at MAXB beats, tail dropped silently
      clear_tallies();
      drive(128'h21, 4'd0, 1'b1, 1'b0);
      drive(128'h22, 4'd0, 1'b0, 1'b0);
      drive(128'h23, 4'd0, 1'b0, 1'b0);
      drive(128'h24, 4'd9, 1'b0, 1'b0);
      drive(128'h25, 4'd0, 1'b0, 1'b0);
      drive(128'h26, 4'd0, 1'b0, 1'b0);
      drive(128'h27, 4'd2, 1'b0, 1'b1);
      drive(128'h30, 4'd1, 1'b1, 1'b1);
      idle(4);
      expect_beat(128'h21, 4'd0, 1'b1, 1'b0);
      expect_beat(128'h22, 4'd0, 1'b0, 1'b0);
      expect_beat(128'h23, 4'd0, 1'b0, 1'b0);
      expect_beat(128'h24, 4'd0, 1'b0, 1'b1);
      expect_beat(128'h30, 4'd1, 1'b1, 1'b1);
      compare_out("t4", 1'b0);
      check_val("t4_le_pulses", n_le, 1);
      check_val("t4_le_cnt", length_err_cnt, 1);
      check_val("t4_no_other_pulses", n_ms + n_ds, 0);

      // Empty forced to 0 on middle beat; stall with sink ready 1,0,0,1
      drive(128'h40, 4'd0, 1'b1, 1'b0);
      out_if.ready = 1'b0;
      in_if.data   = 128'h41;
      in_if.empty  = 4'd5;
      in_if.sop    = 1'b0;
      in_if.eop    = 1'b0;
      @(negedge clk);
      check_val("t5_stall1_in_ready", in_if.ready, 0);
      check_val("t5_stall1_data", out_if.data, 128'h40);
      check_val("t5_stall1_valid", out_if.valid, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("t5_stall2_in_ready", in_if.ready, 0);
      check_val("t5_stall2_data", out_if.data, 128'h40);
      check_val("t5_stall2_sop", out_if.sop, 1);
      @(posedge clk);
      #1 out_if.ready = 1'b1;
      drive(128'h41, 4'd5, 1'b0, 1'b0);
      drive(128'h42, 4'd2, 1'b0, 1'b1);
      idle(4);
      expect_beat(128'h40, 4'd0, 1'b1, 1'b0);
      expect_beat(128'h41, 4'd0, 1'b0, 1'b0);
      expect_beat(128'h42, 4'd2, 1'b0, 1'b1);
      compare_out("t5", 1'b0);

      // Counter saturation, then clear coinciding with a further increment
      clear_tallies();
      for (int i = 0; i < 16; i++) drive(128'(i), 4'd0, 1'b0, 1'b0);
      idle(4);
      check_val("t6_ms_pulses", n_ms, 16);
      check_val("t6_ms_sat", missing_sop_cnt, 15);
      drive(128'h99, 4'd0, 1'b0, 1'b0);
      in_if.valid    = 1'b0;
      counters_clear = 1'b1;
      check_val("t6_pulse_with_clear", missing_sop_error, 1);
      @(posedge clk);
      #1 counters_clear = 1'b0;
      @(negedge clk);
      check_val("t6_clear_prio", missing_sop_cnt, 0);
      check_val("t6_clear_ds", double_sop_cnt, 0);
      check_val("t6_clear_le", length_err_cnt, 0);
      idle(3);
      check_val("t6_after_clear", missing_sop_cnt, 0);
      compare_out("t6", 1'b0);

      // Reset in the middle of a packet
      clear_tallies();
      drive(128'h50, 4'd0, 1'b1, 1'b0);
      in_if.valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_val("t7_rst_in_ready", in_if.ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("t7_rst_valid", out_if.valid, 0);
      check_val("t7_rst_sop_eop", {out_if.sop, out_if.eop}, 0);
      check_val("t7_rst_data", out_if.data, 0);
      check_val("t7_rst_empty", out_if.empty, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(128'h60, 4'd0, 1'b1, 1'b1);
      idle(4);
      expect_beat(128'h50, 4'd0, 1'b1, 1'b0);
      expect_beat(128'h60, 4'd0, 1'b1, 1'b1);
      compare_out("t7", 1'b0);
      check_val("t7_no_double", n_ds, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
